// File: rtl/multicycle_ctrl.sv
// Multicycle control sequencer: ten-state FSM driving datapath selects and strobes,
// plus the NZCV flag register and ARM condition evaluation.
module multicycle_ctrl #(
    parameter int STATE_W = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Instr,
    input  logic [3:0]  ALUFlags,
    output logic        PCWrite,
    output logic        IRWrite,
    output logic        MemWrite,
    output logic        RegWrite,
    output logic        AdrSrc,
    output logic [1:0]  ResultSrc,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ALUControl,
    output logic [1:0]  ImmSrc,
    output logic [1:0]  RegSrc,
    output logic [3:0]  Flags
);

    typedef enum logic [STATE_W-1:0] {
        FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH
    } state_t;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    state_t      state;
    state_t      state_next;
    state_t      out_state;
    logic        cond_ex;
    logic        cond_true;
    logic [1:0]  op;
    logic [5:0]  funct;
    logic [3:0]  cond;
    logic [1:0]  cmd_ctl;
    logic        cmd_valid;
    logic        cmd_writes;
    logic        cmd_arith;
    logic        flag_load;

    assign op    = Instr[27:26];
    assign funct = Instr[25:20];
    assign cond  = Instr[31:28];

    always_comb begin
        cond_true = 1'b0;
        unique case (cond)
            4'b0000: cond_true = Flags[2];
            4'b0001: cond_true = !Flags[2];
            4'b0010: cond_true = Flags[1];
            4'b0011: cond_true = !Flags[1];
            4'b0100: cond_true = Flags[3];
            4'b0101: cond_true = !Flags[3];
            4'b0110: cond_true = Flags[0];
            4'b0111: cond_true = !Flags[0];
            4'b1000: cond_true = Flags[1] && !Flags[2];
            4'b1001: cond_true = !Flags[1] || Flags[2];
            4'b1010: cond_true = (Flags[3] == Flags[0]);
            4'b1011: cond_true = (Flags[3] != Flags[0]);
            4'b1100: cond_true = !Flags[2] && (Flags[3] == Flags[0]);
            4'b1101: cond_true = Flags[2] || (Flags[3] != Flags[0]);
            4'b1110: cond_true = 1'b1;
            4'b1111: cond_true = 1'b0;
        endcase
    end

    // Data-processing command decode; unknown commands execute as ADD with no side effects.
    always_comb begin
        cmd_ctl    = ALU_ADD;
        cmd_valid  = 1'b1;
        cmd_writes = 1'b1;
        cmd_arith  = 1'b0;
        case (funct[4:1])
            4'b0100: cmd_arith = 1'b1;
            4'b0010: begin cmd_ctl = ALU_SUB; cmd_arith = 1'b1; end
            4'b1010: begin cmd_ctl = ALU_SUB; cmd_arith = 1'b1; cmd_writes = 1'b0; end
            4'b0000: cmd_ctl = ALU_AND;
            4'b1100: cmd_ctl = ALU_ORR;
            default: begin cmd_valid = 1'b0; cmd_writes = 1'b0; end
        endcase
    end

    assign flag_load = ((state == EXECR) || (state == EXECI)) && funct[0] && cond_ex && cmd_valid;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= FETCH;
            Flags   <= 4'b0000;
            cond_ex <= 1'b0;
        end else begin
            state <= state_next;
            if (state == DECODE)
                cond_ex <= cond_true;
            if (flag_load) begin
                Flags[3:2] <= ALUFlags[3:2];
                if (cmd_arith)
                    Flags[1:0] <= ALUFlags[1:0];
            end
        end
    end

    always_comb begin
        state_next = FETCH;
        case (state)
            FETCH:  state_next = DECODE;
            DECODE: begin
                case (op)
                    2'b00:   state_next = funct[5] ? EXECI : EXECR;
                    2'b01:   state_next = MEMADR;
                    2'b10:   state_next = BRANCH;
                    default: state_next = FETCH;
                endcase
            end
            MEMADR: state_next = funct[0] ? MEMRD : MEMWR;
            MEMRD:  state_next = MEMWB;
            EXECR,
            EXECI:  state_next = ALUWB;
            default: state_next = FETCH;
        endcase
    end

    // While reset is low the selects show FETCH values and all strobes are held off.
    assign out_state = reset ? state : FETCH;

    // NOTE: every output gets a default before the case so no path can infer a latch.
    always_comb begin
        PCWrite    = 1'b0;
        IRWrite    = 1'b0;
        MemWrite   = 1'b0;
        RegWrite   = 1'b0;
        AdrSrc     = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ALUControl = ALU_ADD;
        ImmSrc     = op;
        RegSrc     = {(op == 2'b01) && !funct[0], op == 2'b10};
        case (out_state)
            FETCH: begin
                IRWrite   = 1'b1;
                PCWrite   = 1'b1;
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            MEMADR: ALUSrcB = 2'b01;
            MEMRD:  AdrSrc = 1'b1;
            MEMWR: begin
                AdrSrc   = 1'b1;
                MemWrite = cond_ex;
            end
            MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = cond_ex;
            end
            EXECR:  ALUControl = cmd_ctl;
            EXECI: begin
                ALUSrcB    = 2'b01;
                ALUControl = cmd_ctl;
            end
            ALUWB:  RegWrite = cond_ex && cmd_writes;
            BRANCH: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                PCWrite   = cond_ex;
            end
            default: ;
        endcase
        if (!reset) begin
            PCWrite  = 1'b0;
            IRWrite  = 1'b0;
            MemWrite = 1'b0;
            RegWrite = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: directed instruction table, mid-instruction reset,
// and random instruction streams scored against an instruction-level model.
module tb_multicycle_ctrl;

    logic        clk;
    logic        reset;
    logic [31:0] Instr;
    logic [3:0]  ALUFlags;
    logic        PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc, ALUSrcA;
    logic [1:0]  ResultSrc, ALUSrcB, ALUControl, ImmSrc, RegSrc;
    logic [3:0]  Flags;

    int total = 0;
    int bad   = 0;

    multicycle_ctrl #(.STATE_W(4)) dut (
        .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags),
        .PCWrite(PCWrite), .IRWrite(IRWrite), .MemWrite(MemWrite), .RegWrite(RegWrite),
        .AdrSrc(AdrSrc), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUControl(ALUControl), .ImmSrc(ImmSrc), .RegSrc(RegSrc), .Flags(Flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One instruction: stimulus plus expected length, final-cycle strobes/selects and flags after.
    typedef struct {
        logic [31:0] instr;
        logic [3:0]  alu;
        int          len;
        logic        pcw;
        logic        regw;
        logic        memw;
        logic [1:0]  res;
        logic        adr;
        logic [1:0]  ctl;
        logic [3:0]  flags;
    } vec_t;

    vec_t tbl[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ARM-style evaluation: base test chosen by Cond[3:1], inverted by Cond[0].
    function automatic logic cond_holds(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v, base;
        {n, z, cy, v} = f;
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cy;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cy & ~z;
            3'd5: base = (n == v);
            3'd6: base = ~z & (n == v);
            default: base = 1'b1;
        endcase
        return base ^ c[0];
    endfunction

    function automatic vec_t model(input logic [31:0] ins, input logic [3:0] alu, input logic [3:0] f);
        vec_t  r;
        logic  pass, valid, arith, writes;
        logic [3:0] cmd;
        pass = cond_holds(ins[31:28], f);
        cmd  = ins[24:21];
        r = '{instr: ins, alu: alu, len: 2, pcw: 1'b0, regw: 1'b0, memw: 1'b0,
              res: 2'b10, adr: 1'b0, ctl: 2'b00, flags: f};
        case (ins[27:26])
            2'b00: begin
                valid = 1'b1; arith = 1'b0; writes = 1'b1;
                case (cmd)
                    4'b0100: arith = 1'b1;
                    4'b0010: begin r.ctl = 2'b01; arith = 1'b1; end
                    4'b1010: begin r.ctl = 2'b01; arith = 1'b1; writes = 1'b0; end
                    4'b0000: r.ctl = 2'b10;
                    4'b1100: r.ctl = 2'b11;
                    default: begin valid = 1'b0; writes = 1'b0; end
                endcase
                r.len  = 4;
                r.res  = 2'b00;
                r.regw = pass & writes;
                if (ins[20] && pass && valid)
                    r.flags = arith ? alu : {alu[3:2], f[1:0]};
            end
            2'b01: begin
                if (ins[20]) begin
                    r.len = 5; r.res = 2'b01; r.regw = pass;
                end else begin
                    r.len = 4; r.res = 2'b00; r.adr = 1'b1; r.memw = pass;
                end
            end
            2'b10: begin
                r.len = 3; r.pcw = pass;
            end
            default: ;
        endcase
        return r;
    endfunction

    // Applies one instruction starting in FETCH and checks it cycle by cycle.
    task automatic run_instr(input vec_t v, input string tag);
        logic [3:0] exp_strb;
        logic       last;
        Instr    = v.instr;
        ALUFlags = v.alu;
        for (int c = 1; c <= v.len; c++) begin
            @(negedge clk);
            last = (c == v.len);
            exp_strb = (c == 1) ? 4'b1100 : {v.pcw & last, 1'b0, v.memw & last, v.regw & last};
            check({tag, " strobes"}, {28'd0, PCWrite, IRWrite, MemWrite, RegWrite}, {28'd0, exp_strb});
            if (c == 2)
                check({tag, " regsrc/immsrc"}, {28'd0, RegSrc, ImmSrc},
                      {28'd0, (v.instr[27:26] == 2'b01) & ~v.instr[20],
                       v.instr[27:26] == 2'b10, v.instr[27:26]});
            if (c == 3 && v.instr[27:26] == 2'b00)
                check({tag, " alucontrol"}, {30'd0, ALUControl}, {30'd0, v.ctl});
            if (last)
                check({tag, " resultsrc/adrsrc"}, {29'd0, ResultSrc, AdrSrc}, {29'd0, v.res, v.adr});
            @(posedge clk);
            #1;
        end
        check({tag, " flags"}, {28'd0, Flags}, {28'd0, v.flags});
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " strobes"}, {28'd0, PCWrite, IRWrite, MemWrite, RegWrite}, 32'd0);
        check({tag, " selects"}, {24'd0, ALUSrcA, ALUSrcB, ResultSrc, AdrSrc, ALUControl},
              {24'd0, 1'b1, 2'b10, 2'b10, 1'b0, 2'b00});
    endtask

    logic [3:0] m_flags;
    logic [3:0] known_cmd[5];
    vec_t       mv;
    logic [31:0] r_ins;

    initial begin
        tbl[0]  = '{32'hE2802005, 4'b0000, 4, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 2'b00, 4'b0000}; // ADD imm
        tbl[1]  = '{32'hE5901000, 4'b0000, 5, 1'b0, 1'b1, 1'b0, 2'b01, 1'b0, 2'b00, 4'b0000}; // LDR
        tbl[2]  = '{32'hE5801064, 4'b0000, 4, 1'b0, 1'b0, 1'b1, 2'b00, 1'b1, 2'b00, 4'b0000}; // STR
        tbl[3]  = '{32'hE0510002, 4'b0100, 4, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 2'b01, 4'b0100}; // SUBS reg
        tbl[4]  = '{32'h0A000001, 4'b0000, 3, 1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 2'b00, 4'b0100}; // BEQ taken
        tbl[5]  = '{32'hE2900000, 4'b0000, 4, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 2'b00, 4'b0000}; // ADDS -> 0000
        tbl[6]  = '{32'h02802005, 4'b0000, 4, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 4'b0000}; // ADDEQ fails
        tbl[7]  = '{32'h1AFFFFFE, 4'b0000, 3, 1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 2'b00, 4'b0000}; // BNE taken
        tbl[8]  = '{32'hE3500000, 4'b0110, 4, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b01, 4'b0110}; // CMP
        tbl[9]  = '{32'hE2100000, 4'b1001, 4, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 2'b10, 4'b1010}; // ANDS keeps C,V
        tbl[10] = '{32'hEC000000, 4'b1111, 2, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 2'b00, 4'b1010}; // illegal op
        tbl[11] = '{32'hE2300000, 4'b1111, 4, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 4'b1010}; // unknown cmd
        tbl[12] = '{32'hE3900000, 4'b0001, 4, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 2'b11, 4'b0010}; // ORRS keeps C,V
        tbl[13] = '{32'h40510002, 4'b1111, 4, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b01, 4'b0010}; // SUBSMI fails

        known_cmd[0] = 4'b0100; known_cmd[1] = 4'b0010; known_cmd[2] = 4'b1010;
        known_cmd[3] = 4'b0000; known_cmd[4] = 4'b1100;

        reset    = 1'b0;
        Instr    = 32'hE2802005;
        ALUFlags = 4'b1111;

        @(posedge clk);
        #1;
        @(negedge clk);
        check_reset_outputs("reset");
        check("reset flags", {28'd0, Flags}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        for (int i = 0; i < 14; i++)
            run_instr(tbl[i], $sformatf("vec%0d", i));

        // LDR aborted by reset in MEMRD; flags were nonzero beforehand.
        Instr    = 32'hE5901000;
        ALUFlags = 4'b0000;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            check($sformatf("abort c%0d strobes", c), {28'd0, PCWrite, IRWrite, MemWrite, RegWrite},
                  (c == 1) ? 32'hC : 32'h0);
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
        @(negedge clk);
        check_reset_outputs("abort memrd");
        @(posedge clk);
        #1;
        @(negedge clk);
        check_reset_outputs("abort hold");
        check("abort flags", {28'd0, Flags}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        run_instr(tbl[0], "post-abort add");

        m_flags = 4'b0000;
        for (int i = 0; i < 300; i++) begin
            r_ins = $urandom;
            if ($urandom_range(0, 3) == 0)
                r_ins[31:28] = 4'b1110;
            if (r_ins[27:26] == 2'b00 && $urandom_range(0, 4) != 0)
                r_ins[24:21] = known_cmd[$urandom_range(0, 4)];
            mv = model(r_ins, 4'($urandom), m_flags);
            run_instr(mv, $sformatf("rnd%0d %08h", i, r_ins));
            m_flags = mv.flags;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Control sequencer for the multicycle build of the processor core: one shared memory for instructions and data, and one ALU reused for PC increment, address generation and execute. Each cycle it decodes the latched instruction fields and the ALU flags into mux selects, ALU operation and gated write strobes. It also holds the NZCV flag register and evaluates ARM condition codes. It replaces the combinational controller of the single-cycle `TOP` and sits beside the datapath registers (PC, IR, Data, A/WD, ALUOut).

## Interface
Parameters:
- `STATE_W`, default 4: state register width; must encode 10 states.

Ports:
- `clk`  in  1: rising-edge clock.
- `reset`  in  1: synchronous, active-low (0 = reset).
- `Instr`  in  32: IR contents. Uses Cond[31:28], Op[27:26], Funct[25:20], Rd[15:12].
- `ALUFlags`  in  4: {N,Z,C,V} from the ALU in the current cycle.
- `PCWrite`  out  1: PC load enable.
- `IRWrite`  out  1: IR load enable.
- `MemWrite`  out  1: memory write strobe.
- `RegWrite`  out  1: register file write strobe.
- `AdrSrc`  out  1: memory address select. 0 = PC, 1 = ALUOut.
- `ResultSrc`  out  2: result select. 00 = ALUOut, 01 = Data, 10 = ALU direct.
- `ALUSrcA`  out  1: ALU A select. 0 = register A, 1 = PC.
- `ALUSrcB`  out  2: ALU B select. 00 = WD register, 01 = ExtImm, 10 = constant 4.
- `ALUControl`  out  2: ALU operation. 00 = ADD, 01 = SUB, 10 = AND, 11 = ORR.
- `ImmSrc`  out  2: immediate format. Driven directly by Op.
- `RegSrc`  out  2: register address selects. [0] = 1 for branch, [1] = 1 for STR.
- `Flags`  out  4: current architectural NZCV.

## Operation
States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH.

Transitions:
- FETCH → DECODE, always.
- DECODE, by Op:
  - Op=00 with Funct[5]=0 → EXECR.
  - Op=00 with Funct[5]=1 → EXECI.
  - Op=01 → MEMADR.
  - Op=10 → BRANCH.
  - Op=11 (illegal) → FETCH.
- MEMADR → MEMRD if L (Funct[0]) = 1, else MEMWR.
- MEMRD → MEMWB.
- EXECR and EXECI → ALUWB.
- MEMWB, MEMWR, ALUWB, BRANCH → FETCH.

Outputs by state (any output not listed is 0):
- FETCH: IRWrite=1, PCWrite=1, AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ALUControl=ADD, ResultSrc=10.
- DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10. This prepares PC+8 for R15 reads.
- MEMADR: ALUSrcA=0, ALUSrcB=01, ALUControl=ADD.
- MEMRD: AdrSrc=1.
- MEMWR: AdrSrc=1, MemWrite=CondEx.
- MEMWB: ResultSrc=01, RegWrite=CondEx.
- EXECR: ALUSrcB=00.
- EXECI: ALUSrcB=01.
  - In both, ALUControl is decoded from Funct[4:1]: 0100 → ADD, 0010 → SUB, 1010 (CMP) → SUB, 0000 → AND, 1100 → ORR.
  - Any other cmd → ADD, with no writeback and no flag update.
- ALUWB: ResultSrc=00, RegWrite=CondEx & NoWrite_n. NoWrite_n is 0 for CMP and for unknown cmd.
- BRANCH: ALUSrcA=0, ALUSrcB=01, ALUControl=ADD, ResultSrc=10, PCWrite=CondEx.

Condition logic:
- CondEx is registered at the end of DECODE from Cond and the current Flags, and held until the next DECODE.
- Codes:
  - 0000 EQ: Z.
  - 0001 NE: !Z.
  - 0010 CS: C.
  - 0011 CC: !C.
  - 0100 MI: N.
  - 0101 PL: !N.
  - 0110 VS: V.
  - 0111 VC: !V.
  - 1000 HI: C&!Z.
  - 1001 LS: !C|Z.
  - 1010 GE: N==V.
  - 1011 LT: N!=V.
  - 1100 GT: !Z&(N==V).
  - 1101 LE: Z|(N!=V).
  - 1110 AL: 1.
  - 1111: 0.

Flags register:
- Loads from ALUFlags at the end of EXECR or EXECI when S (Funct[0]) = 1, CondEx = 1 and cmd is valid.
- N and Z always load. C and V load only for ADD, SUB and CMP; AND and ORR keep C and V.
- Conditional failure: the state sequence is unchanged, and all of PCWrite (except in FETCH), RegWrite and MemWrite are suppressed.

## Timing
- Reset sampled on the rising edge while reset=0:
  - Next state is FETCH; Flags=0000; CondEx=0.
  - While reset=0, every strobe (PCWrite, IRWrite, MemWrite, RegWrite) is forced to 0 combinationally.
  - Selects take their FETCH values.
- First FETCH strobes occur in the first cycle after reset is sampled 1.
- Reset mid-instruction aborts it: no further strobes, and Flags clear.
- Outputs are Moore (state plus registered CondEx/Funct decode). The only exception is the combinational reset gating.
- Instruction latencies:
  - Data-processing: 4 cycles.
  - LDR: 5 cycles.
  - STR: 4 cycles.
  - B: 3 cycles.
  - Illegal op: 2 cycles.
- Instr must remain stable from DECODE to the end of the instruction; the IR is only written in FETCH.
- Flags update and CondEx capture are never in the same cycle, so an S-instruction affects only later instructions.

## Test plan
- Reset then ADD R2,R0,#5 (0xE2802005): states FETCH, DECODE, EXECI, ALUWB. IRWrite and PCWrite are high in cycle 1 only; RegWrite=1 with ResultSrc=00 in cycle 4; ALUControl=00.
- LDR 0xE5901000 takes 5 cycles, with RegWrite and ResultSrc=01 in cycle 5. STR 0xE5801064 takes 4 cycles, with MemWrite=1 and AdrSrc=1 in cycle 4 and RegWrite never high.
- SUBS with ALUFlags=0100 in EXECR gives Flags=0100 afterwards. A following BEQ (0x0A000001) then has PCWrite=1 in cycle 3.
- Flags=0000 with ADDEQ (0x02802005): 4 cycles and RegWrite=0 throughout. With BNE (0x1AFFFFFE), PCWrite=1 in BRANCH.
- CMP (0xE3500000) with ALUFlags=0110: Flags=0110 and RegWrite=0. ANDS with ALUFlags=1001 over Flags=0110: Flags=1010, with C and V kept.
- Drive reset=0 during MEMRD of an LDR: no RegWrite; all strobes are 0 while reset is low; the next cycle after release is FETCH; Flags=0000. Op=11 returns to FETCH after DECODE with no strobes.
